// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative signed multiply / divide unit for the execute stage.
//   Multiply: unsigned shift-add on operand magnitudes, sign applied at the end.
//   Divide:   restoring shift-subtract on magnitudes; quotient truncates toward
//             zero, remainder takes the dividend's sign.
//   Divide by zero skips the iteration and completes in one cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, sampled only while idle
//   op        in   2'b01 signed mul, 2'b10 signed div (others ignored)
//   opa/opb   in   multiplicand/dividend, multiplier/divisor (two's complement)
//   busy      out  high while an operation is in flight (including done cycle)
//   done      out  one-cycle pulse, results valid
//   res_hi    out  product upper half / remainder
//   res_lo    out  product lower half / quotient
//   div_zero  out  divide by zero flag, cleared on the next accept
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for a legal start
// RUN    | one shift-add / shift-subtract step per cycle
// FIX    | apply result signs, register res_hi / res_lo
// DONE   | done pulse, return to IDLE

module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;       // product / quotient sign
    logic               sign_r_q, sign_r_d;   // remainder sign
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // |a| for mul, |b| for div
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               div_zero_q, div_zero_d;

    logic               a_neg, b_neg, accept;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        a_neg  = opa[WIDTH-1];
        b_neg  = opb[WIDTH-1];
        // W-bit unsigned magnitude keeps |-2^(W-1)| exact
        mag_a  = a_neg ? -opa : opa;
        mag_b  = b_neg ? -opb : opb;
        accept = (state_q == S_IDLE) && start && ((op == 2'b01) || (op == 2'b10));

        // Multiply: low half of acc holds the multiplier, shifted out LSB first
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: high half is the partial remainder, low half the dividend/quotient
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};

        prod_fix  = sign_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        sign_d     = sign_q;
        sign_r_d   = sign_r_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_div_d   = op[1];
                    sign_d     = a_neg ^ b_neg;
                    sign_r_d   = a_neg;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (op[1] && (opb == '0)) begin
                        res_lo_d   = '1;
                        res_hi_d   = opa;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        opnd_d  = op[1] ? mag_b : mag_a;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    res_lo_d = sign_q   ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
                    res_hi_d = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    res_lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            sign_r_q   <= 1'b0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            sign_q     <= sign_d;
            sign_r_q   <= sign_r_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign res_hi   = res_hi_q;
    assign res_lo   = res_lo_q;
    assign div_zero = div_zero_q;

endmodule
